// File: rtl/rr_arb_n_if.sv
// ============================================================================
// Module      : rr_arb_n_if
// Description : Request/grant bundle between N bus masters and rr_arb_n.
//               The lock signal exists only when ARB_LOCK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rr_arb_n_if #(
    parameter int N = 4
);
    localparam int ID_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    request;
    logic [N-1:0]    grant;
    logic            grant_valid;
    logic [ID_W-1:0] grant_id;
`ifdef ARB_LOCK_EN
    logic            lock;

    modport master (output request, output lock, input grant, input grant_valid, input grant_id);
    modport slave  (input request, input lock, output grant, output grant_valid, output grant_id);
`else
    modport master (output request, input grant, input grant_valid, input grant_id);
    modport slave  (input request, output grant, output grant_valid, output grant_id);
`endif

endinterface

`default_nettype wire

// File: rtl/rr_arb_n.sv
// ============================================================================
// Module      : rr_arb_n
// Description : N-requester round-robin arbiter with registered one-hot grant,
//               gapless handover and bounded hold time. Optional owner lock
//               enabled by defining ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb_n #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  wire logic  clk,
    input  wire logic  reset_n,
    rr_arb_n_if.slave  arb
);

    localparam int ID_W   = (N > 1) ? $clog2(N) : 1;
    localparam int c_HC_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    localparam logic [c_HC_W-1:0] c_HOLD_LAST = (MAX_HOLD == 0) ? '0 : c_HC_W'(MAX_HOLD - 1);
    localparam logic [ID_W-1:0]   c_LAST_ID   = ID_W'(N - 1);
    localparam logic [ID_W:0]     c_N_EXT     = (ID_W + 1)'(N);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OWNED = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N-1:0]      r_grant;
    logic [N-1:0]      w_grant_nxt;
    logic [ID_W-1:0]   r_grant_id;
    logic [ID_W-1:0]   w_grant_id_nxt;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic [c_HC_W-1:0] r_hold_cnt;
    logic [c_HC_W-1:0] w_hold_nxt;

    logic [N-1:0]      w_others;
    logic [N-1:0]      w_search_vec;
    logic [N-1:0]      w_onehot;
    logic [ID_W-1:0]   w_owner_succ;
    logic [ID_W-1:0]   w_start;
    logic [ID_W-1:0]   w_win;
    logic              w_found;
    logic              w_owner_req;
    logic              w_at_limit;
    logic              w_lock;

`ifdef ARB_LOCK_EN
    assign w_lock = arb.lock;
`else
    assign w_lock = 1'b0;
`endif

    // Circular first-set search: start, start+1, ..., N-1, 0, ..., start-1.
    function automatic logic [ID_W:0] f_rr_search(input logic [N-1:0] vec,
                                                  input logic [ID_W-1:0] start);
        logic            found;
        logic [ID_W-1:0] win;
        logic [ID_W:0]   idx;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, start} + (ID_W + 1)'(k);
            if (idx >= c_N_EXT) begin
                idx = idx - c_N_EXT;
            end
            if (!found && vec[idx[ID_W-1:0]]) begin
                found = 1'b1;
                win   = idx[ID_W-1:0];
            end
        end
        return {found, win};
    endfunction

    always_comb begin
        w_others     = arb.request & ~r_grant;
        w_owner_req  = |(arb.request & r_grant);
        w_owner_succ = (r_grant_id == c_LAST_ID) ? '0 : r_grant_id + ID_W'(1);
        w_search_vec = (r_state == S_IDLE) ? arb.request : w_others;
        w_start      = (r_state == S_IDLE) ? r_ptr : w_owner_succ;
        {w_found, w_win} = f_rr_search(w_search_vec, w_start);
        w_onehot     = N'(1) << w_win;
        w_at_limit   = (MAX_HOLD != 0) && (r_hold_cnt == c_HOLD_LAST) && !w_lock;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_grant_id_nxt = r_grant_id;
        w_ptr_nxt      = r_ptr;
        w_hold_nxt     = r_hold_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt    = S_OWNED;
                    w_grant_nxt    = w_onehot;
                    w_grant_id_nxt = w_win;
                    w_hold_nxt     = '0;
                end
            end
            S_OWNED: begin
                // Owner release and hold-limit preemption share the same handover path.
                if (!w_owner_req || ((|w_others) && w_at_limit)) begin
                    w_ptr_nxt  = w_owner_succ;
                    w_hold_nxt = '0;
                    if (w_found) begin
                        w_grant_nxt    = w_onehot;
                        w_grant_id_nxt = w_win;
                    end else begin
                        w_state_nxt    = S_IDLE;
                        w_grant_nxt    = '0;
                        w_grant_id_nxt = '0;
                    end
                end else if (!w_lock && (MAX_HOLD != 0) && (r_hold_cnt != c_HOLD_LAST)) begin
                    w_hold_nxt = r_hold_cnt + c_HC_W'(1);
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_grant_nxt    = '0;
                w_grant_id_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    assign arb.grant       = r_grant;
    assign arb.grant_valid = (r_state == S_OWNED);
    assign arb.grant_id    = r_grant_id;

endmodule

`default_nettype wire
